// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the RAM A-port arbiter.
package ram_port_arbiter_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned STREAK_W = 4;

  // Reported owner of the RAM port.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_CPU = 2'd1,
    ST_BUSY_DMA = 2'd2
  } state_e;

  // Request payload carried alongside mem_req.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Memory request/response bundle.
//   master: drives req/we/addr/wdata, receives rdata/ready.
//   slave : receives req/we/addr/wdata, drives rdata/ready.
interface ram_port_arbiter_if;
  import ram_port_arbiter_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares the BRAM A-port between the CPU data path and the DMA memory master.
// Fixed CPU priority with a bounded CPU streak so a waiting DMA always gets in.
// Uncontended accesses pass straight through; the grant is held until ready.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   cpu, dma     : slave bundles from the two masters
//   ram          : master bundle to the BRAM A-port
//   arb_owner    : 0 none, 1 CPU, 2 DMA (live selection in IDLE, latched when busy)
//   dma_starved  : one-cycle pulse when DMA wins only because of the streak limit
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_CPU_STREAK = 4  // legal range 1..15
) (
  input  logic                clk,
  input  logic                rst,
  ram_port_arbiter_if.slave   cpu,
  ram_port_arbiter_if.slave   dma,
  ram_port_arbiter_if.master  ram,
  output logic [1:0]          arb_owner,
  output logic                dma_starved
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_STREAK);

  state_e              state, state_nx;
  logic [STREAK_W-1:0] streak, streak_nx;
  owner_e              owner_c;
  logic                starved_c;
  logic                own_req_c;
  mem_req_t            own_bus_c;
  logic                done_c;

  // Owner selection: latched when busy, live priority decision when idle.
  always_comb begin
    owner_c   = OWN_NONE;
    starved_c = 1'b0;
    case (state)
      ST_BUSY_CPU: owner_c = OWN_CPU;
      ST_BUSY_DMA: owner_c = OWN_DMA;
      default: begin
        if (cpu.mem_req && dma.mem_req) begin
          if (streak == STREAK_MAX) begin
            owner_c   = OWN_DMA;
            starved_c = 1'b1;
          end else begin
            owner_c = OWN_CPU;
          end
        end else if (cpu.mem_req) begin
          owner_c = OWN_CPU;
        end else if (dma.mem_req) begin
          owner_c = OWN_DMA;
        end
      end
    endcase
  end

  // Owner's request bundle; the non-owner is never forwarded.
  always_comb begin
    own_req_c = 1'b0;
    own_bus_c = '0;
    case (owner_c)
      OWN_CPU: begin
        own_req_c = cpu.mem_req;
        own_bus_c = '{we: cpu.mem_we, addr: cpu.mem_addr, wdata: cpu.mem_wdata};
      end
      OWN_DMA: begin
        own_req_c = dma.mem_req;
        own_bus_c = '{we: dma.mem_we, addr: dma.mem_addr, wdata: dma.mem_wdata};
      end
      default: ;
    endcase
  end

  assign done_c = own_req_c && ram.mem_ready;

  // Next state and streak counter.
  always_comb begin
    state_nx  = state;
    streak_nx = streak;
    case (state)
      ST_IDLE: begin
        if (own_req_c && !ram.mem_ready)
          state_nx = (owner_c == OWN_CPU) ? ST_BUSY_CPU : ST_BUSY_DMA;
      end
      default: begin
        // Completion, or owner abandoned its request.
        if (!own_req_c || ram.mem_ready)
          state_nx = ST_IDLE;
      end
    endcase

    if (!dma.mem_req || (done_c && owner_c == OWN_DMA))
      streak_nx = '0;
    else if (done_c && owner_c == OWN_CPU && streak != STREAK_MAX)
      streak_nx = streak + STREAK_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      streak <= '0;
    end else begin
      state  <= state_nx;
      streak <= streak_nx;
    end
  end

  // Pass-through outputs, forced quiet while reset is held.
  always_comb begin
    ram.mem_req   = 1'b0;
    ram.mem_we    = 1'b0;
    ram.mem_addr  = '0;
    ram.mem_wdata = '0;
    cpu.mem_ready = 1'b0;
    cpu.mem_rdata = '0;
    dma.mem_ready = 1'b0;
    dma.mem_rdata = '0;
    arb_owner     = OWN_NONE;
    dma_starved   = 1'b0;
    if (!rst) begin
      ram.mem_req   = own_req_c;
      ram.mem_we    = own_bus_c.we && own_req_c;
      ram.mem_addr  = own_bus_c.addr;
      ram.mem_wdata = own_bus_c.wdata;
      cpu.mem_ready = (owner_c == OWN_CPU) && cpu.mem_req && ram.mem_ready;
      cpu.mem_rdata = (owner_c == OWN_CPU) ? ram.mem_rdata : '0;
      dma.mem_ready = (owner_c == OWN_DMA) && dma.mem_req && ram.mem_ready;
      dma.mem_rdata = (owner_c == OWN_DMA) ? ram.mem_rdata : '0;
      arb_owner     = owner_c;
      dma_starved   = starved_c;
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single RAM A-port of dualport_bram between two memory masters:
  - the CPU data path, which carries the RAM leg of the MMIO decode split;
  - the DMA engine's memory master.
- Fixed CPU priority, plus a bounded-starvation rule guaranteeing DMA forward progress.
- Zero added latency on an uncontended access; the grant is latched until the RAM returns ready.
- Sits between the MMIO decode RAM output / DMA master and the BRAM A-port.

Parameters:
- XLEN, 32, data and address width (taken from defines.vh).
- MAX_CPU_STREAK, 4, max consecutive CPU transactions completed while DMA waits before DMA is forced a grant; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- cpu_mem_req  input  1  CPU request, held until cpu_mem_ready.
- cpu_mem_we  input  1  CPU write enable.
- cpu_mem_addr  input  XLEN  CPU byte address.
- cpu_mem_wdata  input  XLEN  CPU write data.
- cpu_mem_rdata  output  XLEN  CPU read data.
- cpu_mem_ready  output  1  CPU transaction complete.
- dma_mem_req / dma_mem_we / dma_mem_addr / dma_mem_wdata  input  1/1/XLEN/XLEN  DMA request bundle, same semantics as CPU.
- dma_mem_rdata  output  XLEN  DMA read data.
- dma_mem_ready  output  1  DMA transaction complete.
- ram_mem_req / ram_mem_we / ram_mem_addr / ram_mem_wdata  output  1/1/XLEN/XLEN  to BRAM A-port.
- ram_mem_rdata  input  XLEN  BRAM read data.
- ram_mem_ready  input  1  BRAM completion.
- arb_owner  output  2  current owner: 0 none, 1 CPU, 2 DMA.
- dma_starved  output  1  pulses one cycle when a DMA grant is forced by the streak rule.

Behaviour:
- Handshake, both masters: the request bundle must stay stable from req rise until the matching ready. A transaction completes in the cycle where granted req && ram_mem_ready.
- States: IDLE, BUSY_CPU, BUSY_DMA. Reset is synchronous, active-high:
  - state = IDLE, streak = 0;
  - all ready outputs 0, all rdata outputs 0;
  - ram_mem_req/we 0, arb_owner 0, dma_starved 0.
- IDLE selection (combinational, same cycle, no extra latency):
  - only CPU requests -> CPU;
  - only DMA requests -> DMA;
  - both request -> DMA if streak == MAX_CPU_STREAK, else CPU.
- IDLE transitions:
  - the selected master's bundle drives ram_mem_* this cycle;
  - if ram_mem_ready is also 1 this cycle, the transaction completes and the state stays IDLE;
  - otherwise the next state is BUSY_CPU or BUSY_DMA.
- BUSY_x:
  - ram_mem_* is driven only from owner x; the other master sees ready = 0 and rdata = 0;
  - on owner req && ram_mem_ready -> IDLE;
  - if the owner's req drops without ready (protocol violation) -> IDLE with no completion signalled; the RAM sees req = 0 in that cycle.
- The non-owner's requests are never forwarded. ram_mem_we = owner_we && owner_req.
- ready and rdata are routed only to the owner: x_mem_ready = owner_is_x && x_req && ram_mem_ready. rdata is zero for the non-owner.
- Streak counter, 4 bits, updated on the clock edge:
  - CPU completion while dma_mem_req = 1 -> increment, saturating at MAX_CPU_STREAK;
  - DMA completion, or any cycle with dma_mem_req = 0 -> 0.
- dma_starved = 1 in the IDLE cycle where DMA is chosen because streak == MAX while cpu_mem_req = 1.
- arb_owner reflects the combinational selection in IDLE and the latched owner in BUSY states.
- Reset asserted mid-transaction: the next state is IDLE, the in-flight access is abandoned, and no ready is issued.

Decomposition:
- defines.vh: XLEN, owner encodings OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_DMA = 2'd2, and state encodings.
- interface.vh: the existing MEM_REQ_PORTS / MEM_RSP_PORTS macros are used for all three bundles.
- No sub-module; the streak counter is inline.

Test Plan:
- BRAM ready after 1 cycle; CPU-only read at 0x100 returning 0xDEADBEEF -> ram_mem_req in the same cycle, cpu_mem_ready 1 cycle later with rdata 0xDEADBEEF, arb_owner 1 then 0.
- Both masters request in the same cycle, streak 0 -> CPU served first; DMA served next, with dma_mem_ready never asserted during the CPU transaction.
- CPU requests back-to-back, DMA held high, MAX = 4 -> exactly 4 CPU completions, then a DMA grant with dma_starved pulsed once, then streak = 0.
- DMA write 0x55AA to 0x200 while the CPU is idle, ram_mem_ready asserted the same cycle -> completes in 1 cycle, state stays IDLE, ram_mem_we = 1.
- Reset asserted during BUSY_DMA with ready still outstanding -> next cycle IDLE, all outputs 0, no dma_mem_ready.
- DMA drops req mid-BUSY -> returns to IDLE and a pending CPU request is granted the following cycle.
